flag_status_unit: RTL and testbench

Holds the processor's architectural NZCV status flags and produces them for the ID-stage condition checker. Computes next flags from the EX-stage ALU result when the instruction has its S bit set. Supports stall, flush, MSR-style direct writes and a one-level exception save/restore. Sits between the EX-stage ALU, which writes the flags, and the condition check, which reads them.

---
 rtl/flag_status_unit.sv | 140 ++++++++++++++
 tb/tb_flag_status_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_unit.sv
// flag_status_unit
// Architectural NZCV status flags, written by the EX-stage ALU and read by
// the ID-stage condition checker. It also handles MSR-style direct writes and
// a one-level exception save/restore.
// Optional feature macro: FLAG_BYPASS_EN. When it is defined, status_fwd
// carries the next-state flags so the following instruction needs no bubble.
// When it is undefined, status_fwd is the registered status.
module flag_status_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_s,
    input  logic [3:0]       ex_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             msr_valid,
    input  logic [3:0]       msr_data,
    input  logic             exc_entry,
    input  logic             exc_return,
    output logic [3:0]       status,
    output logic [3:0]       status_fwd,
    output logic [3:0]       saved_status,
    output logic             in_exc
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_EXC    = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_status;
    logic [3:0] r_saved;
    logic       r_in_exc;

    logic [3:0] w_gen_flags;
    logic [3:0] w_next_status;
    logic       w_ret_take;
    logic       w_ex_take;

    // Build {N,Z,C,V} from an ALU result. Only the arithmetic commands
    // (0010..0101) produce a new carry and overflow. Every other command
    // keeps the current C and V.
    function automatic logic [3:0] gen_flags(
        input logic [WIDTH-1:0] res,
        input logic [3:0]       cmd,
        input logic             c_in,
        input logic             v_in,
        input logic [3:0]       cur
    );
        logic n_f;
        logic z_f;
        logic is_arith;
        n_f      = res[WIDTH-1];
        z_f      = (res == {WIDTH{1'b0}});
        is_arith = (cmd >= 4'd2) && (cmd <= 4'd5);
        if (is_arith) begin
            gen_flags = {n_f, z_f, c_in, v_in};
        end else begin
            gen_flags = {n_f, z_f, cur[1], cur[0]};
        end
    endfunction

    // Decode which update sources qualify this cycle, then pick the next
    // flags. The checks run in priority order, so the first match wins.
    always_comb begin
        w_ret_take    = exc_return && (r_state == ST_EXC);
        w_ex_take     = ex_valid && ex_s && !flush;
        w_gen_flags   = gen_flags(alu_result, ex_cmd, alu_c, alu_v, r_status);
        w_next_status = r_status;
        if (w_ret_take) begin
            w_next_status = r_saved;
        end else if (exc_entry) begin
            // The instruction is squashed, so its flag update and any MSR
            // write are dropped.
            w_next_status = r_status;
        end else if (w_ex_take) begin
            w_next_status = w_gen_flags;
        end else if (msr_valid) begin
            w_next_status = msr_data;
        end else begin
            w_next_status = r_status;
        end
    end

    // Flag register plus the NORMAL/EXC machine with its shadow copy.
    // A stall freezes all of this state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_NORMAL;
            r_status <= RESET_FLAGS;
            r_saved  <= RESET_FLAGS;
            r_in_exc <= 1'b0;
        end else if (!stall) begin
            r_status <= w_next_status;
            case (r_state)
                ST_NORMAL: begin
                    // exc_return is ignored here.
                    if (exc_entry) begin
                        r_saved  <= r_status;
                        r_state  <= ST_EXC;
                        r_in_exc <= 1'b1;
                    end
                end
                ST_EXC: begin
                    if (exc_return) begin
                        r_state  <= ST_NORMAL;
                        r_in_exc <= 1'b0;
                    end else if (exc_entry) begin
                        // A nested entry refreshes the single shadow slot.
                        r_saved <= r_status;
                    end
                end
                default: begin
                    r_state  <= ST_NORMAL;
                    r_in_exc <= 1'b0;
                end
            endcase
        end
    end

    assign status       = r_status;
    assign saved_status = r_saved;
    assign in_exc       = r_in_exc;

`ifdef FLAG_BYPASS_EN
    // Forward the flags the next edge will load. During reset and during a
    // stall, show the registered value.
    assign status_fwd = (!rst_n || stall) ? r_status : w_next_status;
`else
    assign status_fwd = r_status;
`endif

endmodule

// File: tb/tb_flag_status_unit.sv
// Testbench for flag_status_unit. It runs directed scenarios and then
// randomized traffic. All checks are made against a behavioural model of the
// flag rules.
module tb_flag_status_unit;

    localparam int         WIDTH       = 32;
    localparam logic [3:0] RESET_FLAGS = 4'b0000;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic             ex_s;
    logic [3:0]       ex_cmd;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;
    logic             msr_valid;
    logic [3:0]       msr_data;
    logic             exc_entry;
    logic             exc_return;
    logic [3:0]       status;
    logic [3:0]       status_fwd;
    logic [3:0]       saved_status;
    logic             in_exc;

    int n_checks;
    int n_errors;

    // Model state: the architectural view of the flags.
    logic [3:0] m_status;
    logic [3:0] m_saved;
    logic       m_exc;

    flag_status_unit #(.WIDTH(WIDTH), .RESET_FLAGS(RESET_FLAGS)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_s(ex_s), .ex_cmd(ex_cmd),
        .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
        .msr_valid(msr_valid), .msr_data(msr_data),
        .exc_entry(exc_entry), .exc_return(exc_return),
        .status(status), .status_fwd(status_fwd),
        .saved_status(saved_status), .in_exc(in_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Next architectural state from the current inputs.
    task automatic model_next(output logic [3:0] ns, output logic [3:0] nsv, output logic ne);
        logic n_f;
        logic z_f;
        ns  = m_status;
        nsv = m_saved;
        ne  = m_exc;
        if (!stall) begin
            if (exc_return && m_exc) begin
                ns = m_saved;
                ne = 1'b0;
            end else if (exc_entry) begin
                nsv = m_status;
                ne  = 1'b1;
            end else if (ex_valid && ex_s && !flush) begin
                n_f = (alu_result >= 32'h8000_0000);
                z_f = (alu_result == 32'd0);
                if (ex_cmd inside {4'd2, 4'd3, 4'd4, 4'd5})
                    ns = {n_f, z_f, alu_c, alu_v};
                else
                    ns = {n_f, z_f, m_status[1], m_status[0]};
            end else if (msr_valid) begin
                ns = msr_data;
            end
        end
    endtask

    task automatic model_reset();
        m_status = RESET_FLAGS;
        m_saved  = RESET_FLAGS;
        m_exc    = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_s = 1'b0;
        ex_cmd = 4'd0; alu_result = 32'd0; alu_c = 1'b0; alu_v = 1'b0;
        msr_valid = 1'b0; msr_data = 4'd0; exc_entry = 1'b0; exc_return = 1'b0;
    endtask

    // Called at posedge+1 with the inputs already driven. It checks the
    // forwarded flags, clocks one edge, then checks the registered state.
    task automatic run_cycle(input string tag);
        logic [3:0] ns;
        logic [3:0] nsv;
        logic       ne;
        model_next(ns, nsv, ne);
        #1;
`ifdef FLAG_BYPASS_EN
        chk({tag, ".fwd"}, status_fwd, ns);
`else
        chk({tag, ".fwd"}, status_fwd, m_status);
`endif
        @(posedge clk);
        #1;
        m_status = ns;
        m_saved  = nsv;
        m_exc    = ne;
        chk({tag, ".status"}, status, m_status);
        chk({tag, ".saved"}, saved_status, m_saved);
        chk({tag, ".in_exc"}, {3'b000, in_exc}, {3'b000, m_exc});
    endtask

    // Asynchronous reset between edges. It is held across one edge and
    // released at posedge+1.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".status"}, status, RESET_FLAGS);
        chk({tag, ".saved"}, saved_status, RESET_FLAGS);
        chk({tag, ".in_exc"}, {3'b000, in_exc}, 4'b0000);
        chk({tag, ".fwd"}, status_fwd, RESET_FLAGS);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] pre_fwd;
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        model_reset();

        // Reset held while an S-bit update with result 0 is presented.
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_s = 1'b1; ex_cmd = 4'b0110; alu_result = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.status", status, 4'b0000);
        chk("rst.saved", saved_status, 4'b0000);
        chk("rst.in_exc", {3'b000, in_exc}, 4'b0000);
        chk("rst.fwd", status_fwd, 4'b0000);
        rst_n = 1'b1;
        run_cycle("rst_rel");
        chk("rst_rel.const", status, 4'b0100);

        // SUB, then AND keeps C and V.
        ex_cmd = 4'b0100; alu_result = 32'h8000_0000; alu_c = 1'b0; alu_v = 1'b1;
        run_cycle("sub");
        chk("sub.const", status, 4'b1001);
        ex_cmd = 4'b0110; alu_result = 32'd0; alu_c = 1'b1; alu_v = 1'b0;
        run_cycle("and");
        chk("and.const", status, 4'b0101);

        // A flushed update is dropped.
        flush = 1'b1; ex_cmd = 4'b0100; alu_result = 32'd1; alu_c = 1'b1;
        run_cycle("flush");
        chk("flush.const", status, 4'b0101);
        flush = 1'b0; ex_valid = 1'b0; ex_s = 1'b0;

        // A stalled MSR write is ignored, then applies once the stall drops.
        stall = 1'b1; msr_valid = 1'b1; msr_data = 4'b1111;
        run_cycle("stall");
        chk("stall.const", status, 4'b0101);
        stall = 1'b0;
        run_cycle("unstall");
        chk("unstall.const", status, 4'b1111);

        // Exception entry, MSR inside the handler, return, then a stray return.
        msr_data = 4'b0110;
        run_cycle("pre_exc");
        msr_valid = 1'b0;
        exc_entry = 1'b1; ex_valid = 1'b1; ex_s = 1'b1; ex_cmd = 4'b0010;
        alu_result = 32'h8000_0000; alu_c = 1'b1; alu_v = 1'b1;
        run_cycle("exc_in");
        chk("exc_in.saved_c", saved_status, 4'b0110);
        chk("exc_in.status_c", status, 4'b0110);
        chk("exc_in.in_exc_c", {3'b000, in_exc}, 4'b0001);
        exc_entry = 1'b0; ex_valid = 1'b0; ex_s = 1'b0;
        msr_valid = 1'b1; msr_data = 4'b1001;
        run_cycle("exc_msr");
        chk("exc_msr.const", status, 4'b1001);
        msr_valid = 1'b0; exc_return = 1'b1;
        run_cycle("exc_ret");
        chk("exc_ret.status_c", status, 4'b0110);
        chk("exc_ret.in_exc_c", {3'b000, in_exc}, 4'b0000);
        run_cycle("exc_ret2");
        chk("exc_ret2.const", status, 4'b0110);
        exc_return = 1'b0;

        // ADD with a zero result and carry set: check the forwarding timing.
        msr_valid = 1'b1; msr_data = 4'b0000;
        run_cycle("pre_byp");
        msr_valid = 1'b0;
        ex_valid = 1'b1; ex_s = 1'b1; ex_cmd = 4'b0010; alu_result = 32'd0;
        alu_c = 1'b1; alu_v = 1'b0;
        #1;
        pre_fwd = status_fwd;
`ifdef FLAG_BYPASS_EN
        chk("byp.fwd_same", pre_fwd, 4'b0110);
`else
        chk("byp.fwd_same", pre_fwd, 4'b0000);
`endif
        run_cycle("byp");
        chk("byp.status_c", status, 4'b0110);
        chk("byp.fwd_after", status_fwd, 4'b0110);
        idle_inputs();

        // Asynchronous reset in the middle of a handler.
        exc_entry = 1'b1;
        run_cycle("pre_ar");
        exc_entry = 1'b0;
        pulse_reset("async_rst");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 3) == 0);
            ex_valid   = $urandom_range(0, 1);
            ex_s       = $urandom_range(0, 1);
            ex_cmd     = 4'($urandom_range(0, 15));
            alu_result = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            alu_c      = $urandom_range(0, 1);
            alu_v      = $urandom_range(0, 1);
            msr_valid  = ($urandom_range(0, 3) == 0);
            msr_data   = 4'($urandom_range(0, 15));
            exc_entry  = ($urandom_range(0, 9) == 0);
            exc_return = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 79) == 0)
                pulse_reset("rnd_rst");
            else
                run_cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
